// File: rtl/wvb_overflow_reader_pkg.sv
// ----------------------------------------------------------------------------
// wvb_overflow_reader_pkg
// Shared definitions for the waveform-buffer (WVB) blocks: LTC timestamp
// width, the waveform header layout, and the state encodings of the overflow
// record handshake FSM and the overflow drain FSM.
// No ports; imported by wvb_overflow_reader and wvb_drain_ctrl.
// ----------------------------------------------------------------------------
package wvb_overflow_reader_pkg;

   // Width of the local time counter that stamps every waveform.
   localparam int C_LTC_WIDTH      = 49;

   // Waveform header layout as stored in the header FIFO.
   localparam int C_WVB_EVT_LEN_W  = 12;
   localparam int C_WVB_TRIG_SRC_W = 4;

   typedef struct packed {
      logic [C_LTC_WIDTH-1:0]      ltc;
      logic [C_WVB_EVT_LEN_W-1:0]  evt_len;
      logic [C_WVB_TRIG_SRC_W-1:0] trig_src;
      logic                        cs_flag;
   } wvb_hdr_t;

   // Overflow record four-phase handshake.
   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_ACK  = 1'b1
   } hs_state_t;

   // Drain sequence: one header pop and one waveform release per pass.
   typedef enum logic [2:0] {
      RC_IDLE = 3'd0,
      RC_POP  = 3'd1,
      RC_HOLD = 3'd2,
      RC_DONE = 3'd3,
      RC_GAP  = 3'd4
   } rc_state_t;

endpackage

// File: rtl/wvb_overflow_reader_drain.sv
// ----------------------------------------------------------------------------
// wvb_drain_ctrl
// Drains waveforms out of an overflowed waveform buffer, one per 5 cycles:
// POP (header pop) -> HOLD -> DONE (waveform release) -> GAP -> IDLE.
// A started pass always runs to completion regardless of input changes.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_wvb_overflow     buffer has overflowed
//   i_hdr_empty        header FIFO empty
//   i_recover_en       drain enable
//   o_hdr_rdreq        header FIFO pop (one cycle, RC_POP)
//   o_wvb_rddone       waveform released (one cycle, RC_DONE)
// ----------------------------------------------------------------------------
module wvb_drain_ctrl
   import wvb_overflow_reader_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_wvb_overflow,
   input  logic i_hdr_empty,
   input  logic i_recover_en,
   output logic o_hdr_rdreq,
   output logic o_wvb_rddone
);

   rc_state_t r_state;
   rc_state_t w_state_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= RC_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Outputs decode directly from the state register, so they are clean
   // single-cycle pulses.
   always_comb begin
      w_state_nxt  = r_state;
      o_hdr_rdreq  = 1'b0;
      o_wvb_rddone = 1'b0;
      case (r_state)
         RC_IDLE: begin
            if (i_wvb_overflow && i_recover_en && !i_hdr_empty)
               w_state_nxt = RC_POP;
         end
         RC_POP: begin
            o_hdr_rdreq = 1'b1;
            w_state_nxt = RC_HOLD;
         end
         RC_HOLD: w_state_nxt = RC_DONE;
         RC_DONE: begin
            o_wvb_rddone = 1'b1;
            w_state_nxt  = RC_GAP;
         end
         RC_GAP:  w_state_nxt = RC_IDLE;
         default: w_state_nxt = RC_IDLE;
      endcase
   end

endmodule

// File: rtl/wvb_overflow_reader.sv
// ----------------------------------------------------------------------------
// wvb_overflow_reader
// Accepts overflow records (start/end LTC) from the waveform buffer over a
// four-phase req/ack handshake, presents each as a valid/ready record carrying
// the start LTC and the deadtime duration, keeps saturating deadtime and
// record-count statistics, and runs the drain controller that recovers the
// buffer after an overflow.
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_overflow_fifo_req / o_..._ack      record handshake
//   i_overflow_start_ltc / _end_ltc      record bounds
//   i_wvb_overflow, i_hdr_empty,
//   i_recover_en, o_hdr_rdreq,
//   o_wvb_rddone                         drain control (see wvb_drain_ctrl)
//   o_rec_valid / i_rec_ready            output record handshake
//   o_rec_start_ltc, o_rec_dur           output record payload
//   o_dt_total, o_n_overflow             saturating statistics
//   i_clr_stats                          synchronous statistics clear
// ----------------------------------------------------------------------------
module wvb_overflow_reader
   import wvb_overflow_reader_pkg::*;
#(
   parameter int P_LTC_WIDTH = C_LTC_WIDTH,
   parameter int P_DT_WIDTH  = 32,
   parameter int P_CNT_WIDTH = 16
)(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_overflow_fifo_req,
   output logic                   o_overflow_fifo_ack,
   input  logic [P_LTC_WIDTH-1:0] i_overflow_start_ltc,
   input  logic [P_LTC_WIDTH-1:0] i_overflow_end_ltc,
   input  logic                   i_wvb_overflow,
   input  logic                   i_hdr_empty,
   input  logic                   i_recover_en,
   output logic                   o_hdr_rdreq,
   output logic                   o_wvb_rddone,
   output logic                   o_rec_valid,
   input  logic                   i_rec_ready,
   output logic [P_LTC_WIDTH-1:0] o_rec_start_ltc,
   output logic [P_LTC_WIDTH-1:0] o_rec_dur,
   output logic [P_DT_WIDTH-1:0]  o_dt_total,
   output logic [P_CNT_WIDTH-1:0] o_n_overflow,
   input  logic                   i_clr_stats
);

   hs_state_t               r_hs;
   hs_state_t               w_hs_nxt;
   logic                    r_ack;
   logic                    w_slot_free;
   logic                    w_capture;
   logic                    r_rec_valid;
   logic [P_LTC_WIDTH-1:0]  r_rec_start;
   logic [P_LTC_WIDTH-1:0]  r_rec_dur;
   logic [P_LTC_WIDTH-1:0]  w_dur;
   logic [P_DT_WIDTH-1:0]   w_dur_dt;
   logic [P_DT_WIDTH:0]     w_dt_sum;
   logic [P_DT_WIDTH-1:0]   w_dt_nxt;
   logic [P_DT_WIDTH-1:0]   r_dt_total;
   logic [P_CNT_WIDTH-1:0]  r_n_overflow;

   // ---------------------------------------------------------------------
   // Record handshake FSM
   // ---------------------------------------------------------------------
   // The slot is reusable in the same cycle the consumer takes the old record.
   assign w_slot_free = !r_rec_valid || i_rec_ready;

   always_comb begin
      w_hs_nxt  = r_hs;
      w_capture = 1'b0;
      case (r_hs)
         HS_IDLE: begin
            if (i_overflow_fifo_req && w_slot_free) begin
               w_capture = 1'b1;
               w_hs_nxt  = HS_ACK;
            end
         end
         HS_ACK: begin
            // No new capture until req has been seen low.
            if (!i_overflow_fifo_req) w_hs_nxt = HS_IDLE;
         end
         default: w_hs_nxt = HS_IDLE;
      endcase
   end

   // ack is a register off the ACK state: rises one cycle after the FSM
   // enters HS_ACK and drops on the same edge that samples req low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hs  <= HS_IDLE;
         r_ack <= 1'b0;
      end else begin
         r_hs  <= w_hs_nxt;
         r_ack <= (r_hs == HS_ACK) && i_overflow_fifo_req;
      end
   end

   // ---------------------------------------------------------------------
   // Output record slot
   // ---------------------------------------------------------------------
   // Modular subtraction gives the true duration across an LTC wrap.
   assign w_dur = i_overflow_end_ltc - i_overflow_start_ltc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rec_valid <= 1'b0;
         r_rec_start <= '0;
         r_rec_dur   <= '0;
      end else if (w_capture) begin
         r_rec_valid <= 1'b1;
         r_rec_start <= i_overflow_start_ltc;
         r_rec_dur   <= w_dur;
      end else if (i_rec_ready) begin
         r_rec_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Statistics
   // ---------------------------------------------------------------------
   // Fit the duration into the accumulator width; an over-wide duration
   // clips to all-ones so the saturating add below still saturates.
   generate
      if (P_DT_WIDTH > P_LTC_WIDTH) begin : g_dur_ext
         assign w_dur_dt = {{(P_DT_WIDTH-P_LTC_WIDTH){1'b0}}, w_dur};
      end else if (P_DT_WIDTH == P_LTC_WIDTH) begin : g_dur_eq
         assign w_dur_dt = w_dur;
      end else begin : g_dur_clip
         assign w_dur_dt = (|w_dur[P_LTC_WIDTH-1:P_DT_WIDTH]) ? '1
                                                              : w_dur[P_DT_WIDTH-1:0];
      end
   endgenerate

   assign w_dt_sum = {1'b0, r_dt_total} + {1'b0, w_dur_dt};
   assign w_dt_nxt = w_dt_sum[P_DT_WIDTH] ? '1 : w_dt_sum[P_DT_WIDTH-1:0];

   // Clear takes priority over a coincident capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dt_total   <= '0;
         r_n_overflow <= '0;
      end else if (i_clr_stats) begin
         r_dt_total   <= '0;
         r_n_overflow <= '0;
      end else if (w_capture) begin
         r_dt_total <= w_dt_nxt;
         if (!(&r_n_overflow)) r_n_overflow <= r_n_overflow + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Drain controller (independent of the record path)
   // ---------------------------------------------------------------------
   wvb_drain_ctrl u_drain (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_wvb_overflow (i_wvb_overflow),
      .i_hdr_empty    (i_hdr_empty),
      .i_recover_en   (i_recover_en),
      .o_hdr_rdreq    (o_hdr_rdreq),
      .o_wvb_rddone   (o_wvb_rddone)
   );

   assign o_overflow_fifo_ack = r_ack;
   assign o_rec_valid         = r_rec_valid;
   assign o_rec_start_ltc     = r_rec_start;
   assign o_rec_dur           = r_rec_dur;
   assign o_dt_total          = r_dt_total;
   assign o_n_overflow        = r_n_overflow;

endmodule

// File: tb/tb_wvb_overflow_reader.sv
// ----------------------------------------------------------------------------
// tb_wvb_overflow_reader
// Self-checking bench for wvb_overflow_reader. A second instance with an
// 8-bit deadtime accumulator exercises accumulator saturation.
// ----------------------------------------------------------------------------
module tb_wvb_overflow_reader;

   localparam int LW = 49;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req, ack, ack8;
   logic [LW-1:0] s_ltc, e_ltc;
   logic          wvb_ovf, hdr_empty, rec_en;
   logic          rdreq, rddone, rdreq8, rddone8;
   logic          rec_valid, rec_valid8, rec_ready;
   logic [LW-1:0] rec_start, rec_dur, rec_start8, rec_dur8;
   logic [31:0]   dt_total;
   logic [7:0]    dt_total8;
   logic [15:0]   n_ovf, n_ovf8;
   logic          clr;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   longint unsigned m_cnt, m_dt, m_dt8, m_dur;

   always #5 clk = ~clk;

   wvb_overflow_reader u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_overflow_fifo_req(req), .o_overflow_fifo_ack(ack),
      .i_overflow_start_ltc(s_ltc), .i_overflow_end_ltc(e_ltc),
      .i_wvb_overflow(wvb_ovf), .i_hdr_empty(hdr_empty), .i_recover_en(rec_en),
      .o_hdr_rdreq(rdreq), .o_wvb_rddone(rddone),
      .o_rec_valid(rec_valid), .i_rec_ready(rec_ready),
      .o_rec_start_ltc(rec_start), .o_rec_dur(rec_dur),
      .o_dt_total(dt_total), .o_n_overflow(n_ovf), .i_clr_stats(clr)
   );

   wvb_overflow_reader #(.P_DT_WIDTH(8)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_overflow_fifo_req(req), .o_overflow_fifo_ack(ack8),
      .i_overflow_start_ltc(s_ltc), .i_overflow_end_ltc(e_ltc),
      .i_wvb_overflow(wvb_ovf), .i_hdr_empty(hdr_empty), .i_recover_en(rec_en),
      .o_hdr_rdreq(rdreq8), .o_wvb_rddone(rddone8),
      .o_rec_valid(rec_valid8), .i_rec_ready(rec_ready),
      .o_rec_start_ltc(rec_start8), .o_rec_dur(rec_dur8),
      .o_dt_total(dt_total8), .o_n_overflow(n_ovf8), .i_clr_stats(clr)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Reference: duration is the forward distance from start to end on a
   // 2^49 circle; accumulators saturate at their own maximum.
   task automatic model_capture(input longint unsigned s, input longint unsigned e);
      longint unsigned d32, d8;
      if (e >= s) m_dur = e - s;
      else        m_dur = (64'd1 << LW) - s + e;
      d32 = (m_dur > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_dur;
      d8  = (m_dur > 64'd255) ? 64'd255 : m_dur;
      m_dt  = (m_dt + d32 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_dt + d32;
      m_dt8 = (m_dt8 + d8 > 64'd255) ? 64'd255 : m_dt8 + d8;
      m_cnt = (m_cnt == 64'hFFFF) ? m_cnt : m_cnt + 1;
   endtask

   task automatic model_clear();
      m_cnt = 0; m_dt = 0; m_dt8 = 0;
   endtask

   // Full four-phase handshake for one record.
   task automatic send_record(input logic [LW-1:0] s, input logic [LW-1:0] e);
      bit seen;
      s_ltc = s; e_ltc = e; req = 1'b1;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (ack) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL send_ack_timeout: ack=%0b required 1", ack);
      end
      model_capture(s, e);
      req = 1'b0;
      tick();
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL send_ack_drop: ack=%0b required 0", ack);
      end
   endtask

   task automatic consume();
      rec_ready = 1'b1; tick(); rec_ready = 1'b0;
      checks++;
      if (rec_valid !== 1'b0) begin
         errors++;
         $display("FAIL consume: rec_valid=%0b required 0", rec_valid);
      end
   endtask

   task automatic clear_stats();
      clr = 1'b1; tick(); clr = 1'b0;
      model_clear();
      checks++;
      if (n_ovf !== 16'd0 || dt_total !== 32'd0 || dt_total8 !== 8'd0) begin
         errors++;
         $display("FAIL clear: n=%0d dt=%0d dt8=%0d required 0", n_ovf, dt_total, dt_total8);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 0; s_ltc = '0; e_ltc = '0; wvb_ovf = 0; hdr_empty = 1; rec_en = 0;
      rec_ready = 0; clr = 0;
      model_clear();
      tick(); tick();
      checks++;
      if ({ack, rdreq, rddone, rec_valid} !== 4'b0 || rec_start !== '0 || rec_dur !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: ack=%0b rdreq=%0b rddone=%0b valid=%0b start=%0h dur=%0h required 0",
                  ack, rdreq, rddone, rec_valid, rec_start, rec_dur);
      end
      checks++;
      if (dt_total !== '0 || n_ovf !== '0) begin
         errors++;
         $display("FAIL reset_stats: dt=%0d n=%0d required 0", dt_total, n_ovf);
      end
      checks++;
      if ({ack8, rdreq8, rddone8, rec_valid8} !== 4'b0 || rec_start8 !== '0 ||
          rec_dur8 !== '0 || dt_total8 !== '0 || n_ovf8 !== '0) begin
         errors++;
         $display("FAIL reset_dut8: some output nonzero, required all 0");
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      s_ltc = 49'd100; e_ltc = 49'd350; req = 1'b1;
      model_capture(100, 350);
      tick();
      checks++;
      if (ack !== 1'b0 || rec_valid !== 1'b1 || rec_dur !== 49'd250 || rec_start !== 49'd100) begin
         errors++;
         $display("FAIL basic_capture: ack=%0b valid=%0b start=%0d dur=%0d required 0/1/100/250",
                  ack, rec_valid, rec_start, rec_dur);
      end
      checks++;
      if (n_ovf !== 16'd1 || dt_total !== 32'd250) begin
         errors++;
         $display("FAIL basic_stats: n=%0d dt=%0d required 1/250", n_ovf, dt_total);
      end
      tick();
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL basic_ack_rise: ack=%0b required 1", ack);
      end
      req = 1'b0;
      tick();
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL basic_ack_fall: ack=%0b required 0", ack);
      end
      consume();
   endtask

   task automatic test_wrap();
      logic [LW-1:0] s;
      s = {LW{1'b1}} - 49'd9;   // 2^49 - 10
      send_record(s, 49'd5);
      checks++;
      if (rec_dur !== 49'd15 || rec_dur !== m_dur[LW-1:0] || rec_start !== s) begin
         errors++;
         $display("FAIL wrap_dur: dur=%0d start=%0h required 15 start=%0h", rec_dur, rec_start, s);
      end
      consume();
   endtask

   task automatic test_backpressure();
      send_record(49'd1000, 49'd1100);
      s_ltc = 49'd5000; e_ltc = 49'd5077; req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (ack !== 1'b0 || rec_valid !== 1'b1 || rec_start !== 49'd1000 || rec_dur !== 49'd100) begin
            errors++;
            $display("FAIL bp_hold[%0d]: ack=%0b valid=%0b start=%0d dur=%0d required 0/1/1000/100",
                     k, ack, rec_valid, rec_start, rec_dur);
         end
      end
      rec_ready = 1'b1; tick(); rec_ready = 1'b0;
      model_capture(5000, 5077);
      checks++;
      if (rec_valid !== 1'b1 || rec_start !== 49'd5000 || rec_dur !== 49'd77) begin
         errors++;
         $display("FAIL bp_second: valid=%0b start=%0d dur=%0d required 1/5000/77",
                  rec_valid, rec_start, rec_dur);
      end
      tick();
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL bp_ack: ack=%0b required 1", ack);
      end
      req = 1'b0; tick();
      consume();
   endtask

   task automatic test_random();
      logic [LW-1:0] s, e;
      clear_stats();
      for (int i = 0; i < 24; i++) begin
         s = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) e = {$urandom, $urandom};
         else                            e = s + LW'($urandom_range(0, 200000));
         send_record(s, e);
         checks++;
         if (rec_valid !== 1'b1 || rec_start !== s || rec_dur !== m_dur[LW-1:0]) begin
            errors++;
            $display("FAIL rand_rec[%0d]: valid=%0b start=%0h dur=%0h required 1/%0h/%0h",
                     i, rec_valid, rec_start, rec_dur, s, m_dur[LW-1:0]);
         end
         checks++;
         if (n_ovf !== m_cnt[15:0] || dt_total !== m_dt[31:0] || dt_total8 !== m_dt8[7:0]) begin
            errors++;
            $display("FAIL rand_stats[%0d]: n=%0d dt=%0d dt8=%0d required %0d/%0d/%0d",
                     i, n_ovf, dt_total, dt_total8, m_cnt, m_dt, m_dt8);
         end
         consume();
         for (int j = $urandom_range(0, 2); j > 0; j--) tick();
      end
   endtask

   task automatic test_saturate();
      clear_stats();
      send_record(49'd0, 49'd250); consume();
      send_record(49'd300, 49'd310); consume();
      checks++;
      if (dt_total8 !== 8'd255 || dt_total8 !== m_dt8[7:0] || dt_total !== 32'd260) begin
         errors++;
         $display("FAIL sat_dt: dt8=%0d dt=%0d required 255/260", dt_total8, dt_total);
      end
      // clear coincident with the capture edge
      s_ltc = 49'd40; e_ltc = 49'd47; req = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0;
      model_clear();
      checks++;
      if (n_ovf !== 16'd0 || dt_total !== 32'd0 || dt_total8 !== 8'd0) begin
         errors++;
         $display("FAIL sat_clr: n=%0d dt=%0d dt8=%0d required 0", n_ovf, dt_total, dt_total8);
      end
      checks++;
      if (rec_valid !== 1'b1 || rec_dur !== 49'd7) begin
         errors++;
         $display("FAIL sat_clr_rec: valid=%0b dur=%0d required 1/7", rec_valid, rec_dur);
      end
      tick();
      req = 1'b0; tick();
      consume();
   endtask

   // Drain three waveforms while a record handshake runs alongside.
   task automatic test_drain();
      int q_pop[$];
      int q_done[$];
      wvb_ovf = 1; rec_en = 1; hdr_empty = 0;
      fork
         begin
            for (int c = 0; c < 30; c++) begin
               tick();
               if (rdreq)  q_pop.push_back(c);
               if (rddone) q_done.push_back(c);
               if (rdreq && q_pop.size() == 3) begin
                  // pass already under way must still finish
                  hdr_empty = 1; wvb_ovf = 0; rec_en = 0;
               end
            end
         end
         begin
            send_record(49'd7, 49'd19);
            checks++;
            if (rec_dur !== 49'd12 || n_ovf !== m_cnt[15:0]) begin
               errors++;
               $display("FAIL drain_par_rec: dur=%0d n=%0d required 12/%0d", rec_dur, n_ovf, m_cnt);
            end
            consume();
         end
      join
      checks++;
      if (q_pop.size() != 3 || q_done.size() != 3) begin
         errors++;
         $display("FAIL drain_count: pops=%0d dones=%0d required 3/3", q_pop.size(), q_done.size());
      end else begin
         checks++;
         if (q_pop[0] != 0) begin
            errors++;
            $display("FAIL drain_first: pop at %0d required 0", q_pop[0]);
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_pop[i] != 5 * i || q_done[i] != q_pop[i] + 2) begin
               errors++;
               $display("FAIL drain_seq[%0d]: pop=%0d done=%0d required %0d/%0d",
                        i, q_pop[i], q_done[i], 5 * i, 5 * i + 2);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      s_ltc = 49'd20; e_ltc = 49'd30; req = 1'b1;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (ack) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rmid_ack: ack=%0b required 1", ack);
      end
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (ack !== 1'b0 || n_ovf !== 16'd0 || rec_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async: ack=%0b n=%0d valid=%0b required 0/0/0", ack, n_ovf, rec_valid);
      end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (ack) seen = 1;
      end
      model_capture(20, 30);
      checks++;
      if (!seen || n_ovf !== 16'd1 || n_ovf !== m_cnt[15:0] || rec_dur !== 49'd10) begin
         errors++;
         $display("FAIL rmid_reack: ack=%0b n=%0d dur=%0d required 1/1/10", ack, n_ovf, rec_dur);
      end
      req = 1'b0; tick();
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_random();
      test_saturate();
      test_drain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
